// File: rtl/alu_cmd_pkg.sv
// Shared constants for the ALU command issuer: opcodes, command field layout, FSM states.
package alu_cmd_pkg;

  localparam int CMD_W = 15;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
  localparam logic [2:0] OP_SRA = 3'd7;

  localparam int OP_MSB = 14;
  localparam int OP_LSB = 12;
  localparam int RD_MSB = 11;
  localparam int RD_LSB = 8;
  localparam int RS_MSB = 7;
  localparam int RS_LSB = 4;
  localparam int RT_MSB = 3;
  localparam int RT_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/cmd_fifo.sv
// Circular command buffer; DEPTH must be a power of two so the pointers wrap for free.
module cmd_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Buffers packed ALU commands and replays them as registered fields with a one-cycle
// execute strobe, spacing executes by GAP_CYCLES idle cycles.
module alu_cmd_issuer
  import alu_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [14:0]      cmd_data,
  input  logic             stall,
  output logic [2:0]       ALU_Operation,
  output logic [3:0]       Rd,
  output logic [3:0]       Rs,
  output logic [3:0]       Rt,
  output logic             execute,
  output logic             busy,
  output logic [CNT_W-1:0] issued_count
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_INIT = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);

  state_e           state_q, state_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [2:0]       op_q;
  logic [3:0]       rd_q, rs_q, rt_q;
  logic [CNT_W-1:0] cnt_q;

  logic             fifo_full, fifo_empty, decide, load;
  logic [14:0]      head;
  logic [FCW-1:0]   fifo_cnt;

  cmd_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_valid && cmd_ready),
    .wdata_i (cmd_data),
    .pop_i   (load),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // stall is only looked at where a new command could be loaded.
  always_comb begin
    decide = (state_q == ST_IDLE) ||
             (state_q == ST_GAP && gap_q == '0) ||
             (state_q == ST_ISSUE && GAP_CYCLES == 0);
    load   = decide && !fifo_empty && !stall;
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = load ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: state_d = (GAP_CYCLES > 0) ? ST_GAP : (load ? ST_ISSUE : ST_IDLE);
      ST_GAP:   state_d = (gap_q != '0) ? ST_GAP : (load ? ST_ISSUE : ST_IDLE);
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    execute   = (state_q == ST_ISSUE);
    busy      = (fifo_cnt != '0) || (state_q != ST_IDLE);
    cmd_ready = !fifo_full && !rst;
    gap_d     = gap_q;
    if (state_q == ST_ISSUE)                  gap_d = GAP_INIT;
    else if (state_q == ST_GAP && gap_q != '0) gap_d = gap_q - GW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q <= '0;
      op_q  <= '0;
      rd_q  <= '0;
      rs_q  <= '0;
      rt_q  <= '0;
      cnt_q <= '0;
    end else begin
      gap_q <= gap_d;
      if (load) begin
        op_q <= head[OP_MSB:OP_LSB];
        rd_q <= head[RD_MSB:RD_LSB];
        rs_q <= head[RS_MSB:RS_LSB];
        rt_q <= head[RT_MSB:RT_LSB];
      end
      if (execute) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign ALU_Operation = op_q;
  assign Rd            = rd_q;
  assign Rs            = rs_q;
  assign Rt            = rt_q;
  assign issued_count  = cnt_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Two issuers (GAP=1/CNT_W=4 and GAP=0/CNT_W=16) share one stimulus stream and are
// checked every cycle against a timing model of queued commands and earliest-load edges.
module tb_alu_cmd_issuer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, stall = 1'b0;
  logic [14:0] cmd_data = '0;
  logic        rdy [2], exe [2], bsy [2];
  logic [2:0]  aop [2];
  logic [3:0]  rd [2], rs [2], rt [2];
  logic [3:0]  cnt0;
  logic [15:0] cnt1;

  int checks = 0, failures = 0;
  bit started = 0;

  alu_cmd_issuer #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(1), .CNT_W(4)) u0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy[0]), .cmd_data(cmd_data),
    .stall(stall), .ALU_Operation(aop[0]), .Rd(rd[0]), .Rs(rs[0]), .Rt(rt[0]),
    .execute(exe[0]), .busy(bsy[0]), .issued_count(cnt0));

  alu_cmd_issuer #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(0), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy[1]), .cmd_data(cmd_data),
    .stall(stall), .ALU_Operation(aop[1]), .Rd(rd[1]), .Rs(rs[1]), .Rt(rt[1]),
    .execute(exe[1]), .busy(bsy[1]), .issued_count(cnt1));

  always #5 clk = ~clk;

  // Model: a queue, the last loaded command, and the earliest edge a load may occur.
  logic [14:0] mbuf [2][64];
  int          mhead [2] = '{0, 0};
  int          mcnt  [2] = '{0, 0};
  int          mnext [2] = '{0, 0};
  int          mcount[2] = '{0, 0};
  bit          mexec [2] = '{0, 0};
  logic [14:0] mfld  [2] = '{15'd0, 15'd0};
  int          gapv  [2] = '{1, 0};
  int          cmask [2] = '{15, 65535};
  int          ecnt = 0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mhead[i] = 0; mcnt[i] = 0; mnext[i] = 0; mcount[i] = 0; mexec[i] = 0; mfld[i] = '0;
      end else begin
        int  pre;
        bit  ld;
        pre = mcnt[i];
        ld  = (pre != 0) && !stall && (ecnt >= mnext[i]);
        if (mexec[i]) mcount[i] = (mcount[i] + 1) & cmask[i];
        if (ld) begin
          mfld[i]  = mbuf[i][mhead[i]];
          mhead[i] = (mhead[i] + 1) % 64;
          mcnt[i]  = mcnt[i] - 1;
          mnext[i] = ecnt + 1 + gapv[i];
        end
        mexec[i] = ld;
        if (cmd_valid && pre < DEPTH) begin
          mbuf[i][(mhead[i] + mcnt[i]) % 64] = cmd_data;
          mcnt[i] = mcnt[i] + 1;
        end
      end
    end
    ecnt++;
  end

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h exp=%0h t=%0t", nm, idx, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        chk("cmd_ready", i, 32'(rdy[i]), 32'(!rst && mcnt[i] < DEPTH));
        chk("execute", i, 32'(exe[i]), 32'(mexec[i]));
        chk("busy", i, 32'(bsy[i]), 32'((mcnt[i] != 0) || mexec[i] || (mnext[i] >= ecnt)));
        chk("ALU_Operation", i, 32'(aop[i]), 32'(mfld[i][14:12]));
        chk("Rd", i, 32'(rd[i]), 32'(mfld[i][11:8]));
        chk("Rs", i, 32'(rs[i]), 32'(mfld[i][7:4]));
        chk("Rt", i, 32'(rt[i]), 32'(mfld[i][3:0]));
        chk("issued_count", i, (i == 0) ? 32'(cnt0) : 32'(cnt1), 32'(mcount[i]));
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((bsy[0] || bsy[1]) && n < budget) begin
      cyc();
      n++;
    end
    chk("drain_timeout", 0, 32'(n < budget), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    @(posedge clk);
    started = 1;
    cyc();
    chk("lit_ready_in_reset", 0, 32'(rdy[0]), 32'd0);
    chk("lit_reset_count", 0, 32'(cnt0), 32'd0);
    chk("lit_reset_exec", 0, 32'(exe[0]), 32'd0);
    rst = 1'b0;
    cyc();
    chk("lit_ready_after_reset", 0, 32'(rdy[0]), 32'd1);

    // single command {op=0, rd=3, rs=1, rt=2}
    cmd_valid = 1'b1; cmd_data = 15'h0312;
    cyc();
    cmd_valid = 1'b0;
    cyc();
    for (int i = 0; i < 2; i++) begin
      chk("lit_t1_exec", i, 32'(exe[i]), 32'd1);
      chk("lit_t1_fields", i, {17'd0, aop[i], rd[i], rs[i], rt[i]}, 32'h0312);
    end
    cyc();
    chk("lit_exec_one_cycle", 0, 32'(exe[0]), 32'd0);
    chk("lit_count_one", 0, 32'(cnt0), 32'd1);
    chk("lit_busy_in_gap", 0, 32'(bsy[0]), 32'd1);
    chk("lit_busy_nogap", 1, 32'(bsy[1]), 32'd0);
    cyc();
    chk("lit_busy_done", 0, 32'(bsy[0]), 32'd0);

    // stall with valid held: only DEPTH pushes fit
    stall = 1'b1; cmd_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cmd_data = 15'($urandom);
      cyc();
    end
    chk("lit_full_ready", 0, 32'(rdy[0]), 32'd0);
    chk("lit_full_ready", 1, 32'(rdy[1]), 32'd0);
    cmd_valid = 1'b0; stall = 1'b0;
    wait_idle(60);

    // reset while executing with two entries left
    stall = 1'b1; cmd_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cmd_data = 15'($urandom);
      cyc();
    end
    cmd_valid = 1'b0; stall = 1'b0;
    n = 0;
    while (!exe[0] && n < 10) begin
      cyc();
      n++;
    end
    chk("exec_wait_timeout", 0, 32'(n < 10), 32'd1);
    rst = 1'b1;
    cyc();
    chk("lit_rst_exec", 0, 32'(exe[0]), 32'd0);
    chk("lit_rst_fields", 0, {17'd0, aop[0], rd[0], rs[0], rt[0]}, 32'd0);
    chk("lit_rst_count", 1, 32'(cnt1), 32'd0);
    rst = 1'b0;
    repeat (5) cyc();
    chk("lit_no_exec_after_rst", 0, 32'(cnt0), 32'd0);
    chk("lit_empty_after_rst", 1, 32'(bsy[1]), 32'd0);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      cmd_valid = ($urandom_range(0, 2) != 0);
      stall     = ($urandom_range(0, 4) == 0);
      cmd_data  = 15'($urandom);
      rst       = ($urandom_range(0, 99) == 0);
      cyc();
    end
    rst = 1'b0; cmd_valid = 1'b0; stall = 1'b0;
    wait_idle(60);

    // 17 issues: 4-bit counter wraps to 1
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 17; k++) begin
      cmd_valid = 1'b1; cmd_data = 15'($urandom);
      cyc();
      cmd_valid = 1'b0;
      cyc();
    end
    wait_idle(40);
    chk("lit_wrap_count", 0, 32'(cnt0), 32'd1);
    chk("lit_count_17", 1, 32'(cnt1), 32'd17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Front end that drives the register/ALU execute datapath.
- Accepts packed ALU commands over a valid/ready handshake and buffers them in a small FIFO.
- Replays them one at a time as registered ALU_Operation/Rd/Rs/Rt fields with a single-cycle execute strobe.
- Enforces a programmable idle gap between executes so each register-bank write settles before the next read.

Parameters:
FIFO_DEPTH, 4, command buffer entries; power of two, minimum 2
GAP_CYCLES, 1, idle cycles forced after each execute pulse; 0 allows back-to-back executes
CNT_W, 16, width of issued_count

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command present on cmd_data
cmd_ready  output  1  block can accept a command this cycle
cmd_data  input  15  {op[14:12], rd[11:8], rs[7:4], rt[3:0]}
stall  input  1  when high, no new issue starts; an in-flight execute still completes
ALU_Operation  output  3  opcode of the issued command, registered
Rd  output  4  destination register index, registered
Rs  output  4  source register index, registered
Rt  output  4  source register index, registered
execute  output  1  one-cycle write strobe to the register bank
busy  output  1  FIFO non-empty or state not IDLE
issued_count  output  CNT_W  number of execute pulses since reset; wraps

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Reset values: FIFO empty; state IDLE; ALU_Operation/Rd/Rs/Rt = 0; execute = 0; issued_count = 0; busy = 0.
- cmd_ready is 0 in any cycle with rst high.
- Reset mid-operation: all buffered commands are discarded. If execute is high in the reset cycle, it is 0 in the following cycle.
- Handshake:
  - A push occurs on an edge where cmd_valid && cmd_ready.
  - cmd_ready = !full && !rst. There is no bypass: when full, cmd_ready stays 0 even if a pop occurs in the same cycle.
  - cmd_data is captured only on a push. cmd_data while cmd_valid is low is ignored.
- FIFO:
  - Circular buffer with read/write pointers that wrap at FIFO_DEPTH.
  - Occupancy counter is 0..FIFO_DEPTH.
  - A simultaneous push and pop leaves occupancy unchanged.
  - There is no pop when empty and no push when full.
- FSM states:
  - IDLE: if FIFO non-empty and !stall, the head fields are loaded into the output registers, the head is popped, and the state goes to ISSUE.
  - ISSUE: execute = 1 for exactly this one cycle, and issued_count increments.
    - If GAP_CYCLES > 0, next state is GAP with gap counter = GAP_CYCLES-1.
    - If GAP_CYCLES = 0 and FIFO non-empty and !stall, the next head is loaded and popped, and the state stays ISSUE (back-to-back execute).
    - Otherwise next state is IDLE.
  - GAP: execute = 0 and output fields held. When the counter is 0, apply the same exit rule as IDLE; otherwise decrement.
- execute is decoded from the registered state (state == ISSUE). It is glitch-free, with no combinational path from cmd_valid.
- Output fields hold their last issued value through IDLE/GAP until the next load.
- Latency:
  - Into an empty FIFO in IDLE with stall = 0: a command pushed at edge t0 is loaded at edge t1, and execute is high during cycle t1..t2.
  - Throughput is one execute per (1 + GAP_CYCLES) cycles.
- stall:
  - Sampled only at load decisions (IDLE, GAP exit, and ISSUE when GAP_CYCLES = 0).
  - Pushes continue while stalled until the FIFO is full.
- busy = (occupancy != 0) || (state != IDLE).
- issued_count wraps from 2^CNT_W-1 to 0.

Decomposition:
- Shared package alu_cmd_pkg contains:
  - Opcode constants: OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_XOR=4, OP_SLL=5, OP_SRL=6, OP_SRA=7.
  - cmd_data field positions (OP_MSB/LSB, RD_MSB/LSB, RS_MSB/LSB, RT_MSB/LSB).
  - FSM state encodings.
- One sub-module, cmd_fifo: parameterised width/depth, synchronous reset, with push, pop, full, empty and count.
- The FSM, gap counter and output registers stay in alu_cmd_issuer.

Test Plan:
- Reset, then push {op=0, rd=3, rs=1, rt=2} once -> ALU_Operation=0, Rd=3, Rs=1, Rt=2 valid at edge t1; execute high for exactly one cycle, in t1..t2; issued_count=1; busy returns to 0 after the GAP.
- GAP_CYCLES=1: push 3 commands on consecutive cycles -> execute pulses 2 cycles apart; fields change only on load edges; issued_count=3.
- GAP_CYCLES=0 with FIFO pre-filled with 4 commands -> 4 consecutive execute cycles, opcodes in push order.
- Hold cmd_valid=1 with stall=1 for 6 cycles -> exactly 4 pushes accepted, then cmd_ready=0; no execute occurs. Release stall -> 4 executes in order, and cmd_ready returns to 1 after the first pop.
- Assert rst in the cycle execute is high with 2 entries queued -> execute=0 and fields=0 in the next cycle; no further executes; FIFO empty; issued_count=0.
- CNT_W=4: issue 17 commands -> issued_count reads 1 (wrap verified).
